// File: rtl/cacheline_element_unpacker_if.sv
// cacheline_element_unpacker_if: cacheline input stream and element-beat output stream.
interface cacheline_element_unpacker_if #(
    parameter int CACHELINE_SIZE = 128,
    parameter int ELEMENT_SIZE   = 4,
    parameter int LANES          = 2
);
    localparam int EB       = ELEMENT_SIZE * 8;
    localparam int ELEMS    = CACHELINE_SIZE / ELEMENT_SIZE;
    localparam int OFF_BITS = $clog2(CACHELINE_SIZE);
    localparam int CNT_BITS = $clog2(ELEMS) + 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [CACHELINE_SIZE*8-1:0] in_line;
    logic [OFF_BITS-1:0]         in_offset;
    logic [CNT_BITS-1:0]         in_count;
    logic                        in_swap;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*EB-1:0]         out_data;
    logic [LANES-1:0]            out_mask;
    logic                        out_last;

    modport master (
        output in_valid, in_line, in_offset, in_count, in_swap, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_last
    );

    modport slave (
        input  in_valid, in_line, in_offset, in_count, in_swap, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_last
    );
endinterface

// File: rtl/cacheline_element_unpacker.sv
// cacheline_element_unpacker: buffers tagged cachelines and emits LANES elements per beat.
module cacheline_element_unpacker #(
    parameter int CACHELINE_SIZE = 128,
    parameter int ELEMENT_SIZE   = 4,
    parameter int LANES          = 2,
    parameter int BUFFER_DEPTH   = 2
) (
    input  logic                         clock,
    input  logic                         rstn,
    input  logic                         enabled,
    cacheline_element_unpacker_if.slave  bus,
    output logic [$clog2(BUFFER_DEPTH):0] buffer_fill,
    output logic                         error_overrun
);
    localparam int EB       = ELEMENT_SIZE * 8;
    localparam int ELEMS    = CACHELINE_SIZE / ELEMENT_SIZE;
    localparam int LB       = CACHELINE_SIZE * 8;
    localparam int CNT_BITS = $clog2(ELEMS) + 1;
    localparam int CW       = CNT_BITS + 1;
    localparam int SB       = $clog2(ELEMS);
    localparam int PB       = $clog2(BUFFER_DEPTH);
    localparam int FB       = PB + 1;

    logic [LB-1:0]       line_mem  [BUFFER_DEPTH];
    logic [CW-1:0]       start_mem [BUFFER_DEPTH];
    logic [CW-1:0]       end_mem   [BUFFER_DEPTH];
    logic [PB-1:0]       rd_ptr, wr_ptr, nidx;
    logic [CW-1:0]       cursor, in_start, in_sum, in_end, src_cur, src_end;
    logic [LB-1:0]       swapped, src_line;
    logic [FB-1:0]       remaining;
    logic                acc, hold, cont, last_pop, zero_pop, pop, src_ok, nxt_last;
    logic [LANES*EB-1:0] nxt_data;
    logic [LANES-1:0]    nxt_mask;

    for (genvar i = 0; i < ELEMS; i++) begin : g_el
        for (genvar j = 0; j < ELEMENT_SIZE; j++) begin : g_by
            assign swapped[i*EB + j*8 +: 8] = bus.in_swap ? bus.in_line[i*EB + (ELEMENT_SIZE-1-j)*8 +: 8]
                                                          : bus.in_line[i*EB + j*8 +: 8];
        end
    end

    assign in_start     = CW'(bus.in_offset >> $clog2(ELEMENT_SIZE));
    assign in_sum       = in_start + CW'(bus.in_count);
    assign in_end       = in_sum > CW'(ELEMS) ? CW'(ELEMS) : in_sum;
    assign bus.in_ready = rstn && enabled && (buffer_fill < FB'(BUFFER_DEPTH));
    assign acc          = bus.in_valid && bus.in_ready;
    assign hold         = bus.out_valid && !bus.out_ready;
    assign cont         = bus.out_valid && bus.out_ready && !bus.out_last;
    assign last_pop     = bus.out_valid && bus.out_ready && bus.out_last;
    // An idle output with a non-empty FIFO means the head holds no elements.
    assign zero_pop     = !bus.out_valid && (buffer_fill != '0) && (start_mem[rd_ptr] >= end_mem[rd_ptr]);
    assign pop          = last_pop || zero_pop;
    assign remaining    = buffer_fill - FB'(pop);
    assign nidx         = rd_ptr + PB'(pop);

    // Next beat comes from the current head, the entry behind it, or the line arriving now.
    always_comb begin
        src_line = cont ? line_mem[rd_ptr] : (remaining != '0) ? line_mem[nidx] : swapped;
        src_cur  = cont ? cursor + CW'(LANES) : (remaining != '0) ? start_mem[nidx] : in_start;
        src_end  = cont ? end_mem[rd_ptr] : (remaining != '0) ? end_mem[nidx] : in_end;
        src_ok   = cont || ((remaining != '0) ? (start_mem[nidx] < end_mem[nidx]) : (acc && in_start < in_end));
        nxt_mask = '0;
        nxt_data = '0;
        for (int k = 0; k < LANES; k++) begin
            nxt_mask[k] = src_ok && (src_cur + CW'(k) < src_end);
            nxt_data[k*EB +: EB] = nxt_mask[k] ? src_line[(src_cur[SB-1:0] + SB'(k))*EB +: EB] : '0;
        end
        nxt_last = src_ok && (src_cur + CW'(LANES) >= src_end);
    end

    always_ff @(posedge clock) begin
        if (acc) begin
            line_mem[wr_ptr]  <= swapped;
            start_mem[wr_ptr] <= in_start;
            end_mem[wr_ptr]   <= in_end;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            buffer_fill   <= '0;
            cursor        <= '0;
            error_overrun <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_mask  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (acc) wr_ptr <= wr_ptr + PB'(1);
            if (pop) rd_ptr <= nidx;
            buffer_fill <= buffer_fill + FB'(acc) - FB'(pop);
            if (acc && in_sum > CW'(ELEMS)) error_overrun <= 1'b1;
            if (!hold) begin
                cursor        <= src_cur;
                bus.out_valid <= src_ok;
                bus.out_data  <= nxt_data;
                bus.out_mask  <= nxt_mask;
                bus.out_last  <= nxt_last;
            end
        end
    end
endmodule
